rr_scan_sel: RTL and testbench

RR_SCAN_SEL -- requirements
Module: rr_scan_sel

---
 rtl/rr_scan_sel.sv | 115 +++++++++++
 tb/tb_rr_scan_sel.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_scan_sel.sv
// Round-robin channel scanner driving a 2-to-4 decoder select (A,B) and enable.
// Each grant lasts a latched number of non-hold cycles, followed by one
// break-before-make GAP cycle with the decoder disabled.
module rr_scan_sel #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    output logic               A,
    output logic               B,
    output logic               EN,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;     // channel currently on the decoder select
    logic [1:0]         last_reg, last_next;   // round-robin pointer (last winner)
    logic [DWELL_W-1:0] cnt_reg, cnt_next;     // non-hold cycles elapsed in this grant
    logic [DWELL_W-1:0] len_reg, len_next;     // latched grant length, never 0

    logic [1:0] cand [4];
    logic [3:0] hit;
    logic [1:0] win;
    logic       last_cycle;

    // Candidate k is the k-th channel after the last winner; hit marks a request there.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rr
            assign cand[gi] = last_reg + 2'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Pick the nearest requesting channel after the last winner (lowest offset wins).
    always_comb begin
        win = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                win = cand[k];
            end
        end
    end

    // Counter stops one short of the length, so it can never wrap inside a grant.
    assign last_cycle = (cnt_reg == len_reg - DWELL_W'(1));

    // Next-state logic: arbitrate from IDLE/GAP, count non-hold cycles in GRANT.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE, GAP: begin
                if (|req) begin
                    state_next = GRANT;
                    idx_next   = win;
                    last_next  = win;
                    cnt_next   = '0;
                    len_next   = (dwell == '0) ? DWELL_W'(1) : dwell;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (!hold) begin
                    if (last_cycle) begin
                        state_next = GAP;
                    end else begin
                        cnt_next = cnt_reg + DWELL_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; pointer starts at 3 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            last_reg  <= 2'd3;
            cnt_reg   <= '0;
            len_reg   <= DWELL_W'(1);
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
        end
    end

    assign A    = idx_reg[1];
    assign B    = idx_reg[0];
    assign EN   = (state_reg == GRANT);
    assign busy = (state_reg != IDLE);
    // done is suppressed while a reset is pending so an aborted grant never reports completion.
    assign done = (state_reg == GRANT) && !hold && last_cycle && !rst;

endmodule

// File: tb/tb_rr_scan_sel.sv
// Directed testbench for rr_scan_sel: per-cycle checks of {EN,A,B,done,busy}
// and of an attached active-low 2-to-4 decoder.
module tb_rr_scan_sel;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       hold;
    logic       A, B, EN, busy, done;
    logic [3:0] dec_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    rr_scan_sel #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dwell (dwell),
        .hold  (hold),
        .A     (A),
        .B     (B),
        .EN    (EN),
        .busy  (busy),
        .done  (done)
    );

    // Active-low 2-to-4 decoder fed by the select outputs.
    assign dec_out = EN ? ~(4'b0001 << {A, B}) : 4'b1111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {EN, A, B, done, busy};
    endfunction

    function automatic logic [3:0] dec_of(input logic [4:0] e);
        logic [1:0] s;
        s = e[3:2];
        return e[4] ? ~(4'b0001 << s) : 4'b1111;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b0000; hold = 1'b0; dwell = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; hold = 1'b1; dwell = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            $display("reset cyc=%0d obs=%b dec=%b", i, obs(), dec_out);
            vec_cnt++;
            if (obs() !== 5'b00000) begin
                err_cnt++;
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, obs(), 5'b00000);
            end
            vec_cnt++;
            if (dec_out !== 4'b1111) begin
                err_cnt++;
                $display("FAIL reset_dec cyc=%0d got=%b exp=%b", i, dec_out, 4'b1111);
            end
        end
        rst = 1'b0; req = 4'b0000; hold = 1'b0;
    endtask

    // Single requester ch2, dwell=3: repeats after one GAP, then goes idle when dropped.
    task automatic test_single();
        logic [4:0] exp [9];
        exp = '{5'b11001, 5'b11001, 5'b11011, 5'b01001,
                5'b11001, 5'b11001, 5'b11011, 5'b01001, 5'b01000};
        do_reset();
        req = 4'b0100; dwell = 4'd3;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i == 6) req = 4'b0000;
            @(negedge clk);
            $display("single cyc=%0d obs=%b dec=%b", i, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL single cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL single_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    // All requesting, dwell=1: order 0,1,2,3,0 with GAP between.
    task automatic test_round_robin();
        logic [4:0] exp [9];
        exp = '{5'b10011, 5'b00001, 5'b10111, 5'b00101, 5'b11011,
                5'b01001, 5'b11111, 5'b01101, 5'b10011};
        do_reset();
        req = 4'b1111; dwell = 4'd1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); @(negedge clk);
            $display("rr cyc=%0d obs=%b dec=%b", i, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL round_robin cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL rr_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    // dwell=0 behaves as a one-cycle grant with done in that cycle.
    task automatic test_dwell_zero();
        logic [4:0] exp [3];
        exp = '{5'b10011, 5'b00001, 5'b00000};
        do_reset();
        req = 4'b0001; dwell = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req = 4'b0000;
            @(negedge clk);
            $display("dwell0 cyc=%0d obs=%b dec=%b", i, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL dwell_zero cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL dwell0_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    // ch1, dwell=4, hold for 2 cycles, dwell changed mid-grant: 6 EN cycles.
    task automatic test_hold();
        logic [4:0] exp [8];
        logic       hv  [8];
        exp = '{5'b10101, 5'b10101, 5'b10101, 5'b10101,
                5'b10101, 5'b10111, 5'b00101, 5'b00100};
        hv  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        req = 4'b0010; dwell = 4'd4;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            hold = hv[i];
            if (i == 1) dwell = 4'd1;
            if (i == 6) req = 4'b0000;
            @(negedge clk);
            $display("hold cyc=%0d hold=%b obs=%b dec=%b", i, hold, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL hold_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    // ch2 request dropped after 1 cycle: grant still lasts 3, then GAP, IDLE.
    task automatic test_drop_req();
        logic [4:0] exp [5];
        exp = '{5'b11001, 5'b11001, 5'b11011, 5'b01001, 5'b01000};
        do_reset();
        req = 4'b0100; dwell = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req = 4'b0000;
            @(negedge clk);
            $display("drop cyc=%0d obs=%b dec=%b", i, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL drop_req cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL drop_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    // Reset in the 2nd cycle of a dwell=5 grant on ch1; next grant with all requests is ch0.
    task automatic test_rst_mid_grant();
        logic [4:0] exp [5];
        logic       rv  [5];
        exp = '{5'b10101, 5'b10101, 5'b00000, 5'b10001, 5'b10001};
        rv  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        req = 4'b0010; dwell = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rst = rv[i];
            if (i >= 2) req = 4'b1111;
            @(negedge clk);
            $display("rstmid cyc=%0d rst=%b obs=%b dec=%b", i, rst, obs(), dec_out);
            vec_cnt++;
            if (obs() !== exp[i]) begin
                err_cnt++;
                $display("FAIL rst_mid cyc=%0d got=%b exp=%b", i, obs(), exp[i]);
            end
            vec_cnt++;
            if (dec_out !== dec_of(exp[i])) begin
                err_cnt++;
                $display("FAIL rst_mid_dec cyc=%0d got=%b exp=%b", i, dec_out, dec_of(exp[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; dwell = 4'd0; hold = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_dwell_zero();
        test_hold();
        test_drop_req();
        test_rst_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
